// File: rtl/geofence_driver_if.sv
// Point-load, coordinate-drive and result bundle for geofence_driver.
// slave is the driver side; master is the producer/receiver side.
interface geofence_driver_if;
    logic       in_valid;
    logic       in_ready;
    logic [9:0] in_x;
    logic [9:0] in_y;
    logic [9:0] X;
    logic [9:0] Y;
    logic       drv_active;
    logic       fence_valid;
    logic       fence_inside;
    logic       res_valid;
    logic       res_inside;
    logic       res_timeout;
    logic [7:0] set_cnt;
    logic [7:0] inside_cnt;

    modport slave (
        input  in_valid, in_x, in_y, fence_valid, fence_inside,
        output in_ready, X, Y, drv_active, res_valid, res_inside, res_timeout,
               set_cnt, inside_cnt
    );

    modport master (
        output in_valid, in_x, in_y, fence_valid, fence_inside,
        input  in_ready, X, Y, drv_active, res_valid, res_inside, res_timeout,
               set_cnt, inside_cnt
    );
endinterface

// File: rtl/geofence_driver.sv
// Ping-pong buffered geofence point driver: loads target+6 vertices, bursts them out, collects verdict.
// Optional WAIT timeout enabled by defining GEOFENCE_DRV_TIMEOUT_EN.
module geofence_driver (
    input logic               clk,
    input logic               reset,
    geofence_driver_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, SEND, WAIT, RESULT} state_t;

    state_t     state;
    logic [9:0] mem_x [2][7];
    logic [9:0] mem_y [2][7];
    logic [1:0] full;
    logic       wr_bank;
    logic       rd_bank;
    logic [2:0] wr_ptr;
    logic [2:0] snd_idx;
    logic [9:0] x_q;
    logic [9:0] y_q;
    logic       drv_q;
    logic       res_valid_q;
    logic       res_inside_q;
    logic [7:0] set_q;
    logic [7:0] inside_q;
    logic       wr_fire;
    logic       wr_last;
    logic       rd_fill;
    logic       oth_fill;
`ifdef GEOFENCE_DRV_TIMEOUT_EN
    logic [5:0] wait_cnt;
    logic       res_timeout_q;
`endif

    assign bus.in_ready   = ~(full[0] & full[1]);
    assign bus.X          = x_q;
    assign bus.Y          = y_q;
    assign bus.drv_active = drv_q;
    assign bus.res_valid  = res_valid_q;
    assign bus.res_inside = res_inside_q;
    assign bus.set_cnt    = set_q;
    assign bus.inside_cnt = inside_q;
`ifdef GEOFENCE_DRV_TIMEOUT_EN
    assign bus.res_timeout = res_timeout_q;
`else
    assign bus.res_timeout = 1'b0;
`endif

    assign wr_fire = bus.in_valid & bus.in_ready;
    assign wr_last = wr_fire && (wr_ptr == 3'd6);
    // A bank completing on this edge counts as full so SEND starts with no idle gap.
    assign rd_fill  = full[rd_bank]  | (wr_last & (wr_bank == rd_bank));
    assign oth_fill = full[~rd_bank] | (wr_last & (wr_bank != rd_bank));

    always_ff @(posedge clk) begin
        if (wr_fire) begin
            mem_x[wr_bank][wr_ptr] <= bus.in_x;
            mem_y[wr_bank][wr_ptr] <= bus.in_y;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            full         <= '0;
            wr_bank      <= 1'b0;
            rd_bank      <= 1'b0;
            wr_ptr       <= '0;
            snd_idx      <= '0;
            x_q          <= '0;
            y_q          <= '0;
            drv_q        <= 1'b0;
            res_valid_q  <= 1'b0;
            res_inside_q <= 1'b0;
            set_q        <= '0;
            inside_q     <= '0;
`ifdef GEOFENCE_DRV_TIMEOUT_EN
            wait_cnt      <= '0;
            res_timeout_q <= 1'b0;
`endif
        end else begin
            if (wr_fire) begin
                if (wr_ptr == 3'd6) begin
                    full[wr_bank] <= 1'b1;
                    wr_ptr        <= '0;
                    wr_bank       <= ~wr_bank;
                end else begin
                    wr_ptr <= wr_ptr + 3'd1;
                end
            end

            res_valid_q <= 1'b0;

            case (state)
                IDLE: begin
                    if (rd_fill) begin
                        state   <= SEND;
                        snd_idx <= '0;
                        x_q     <= mem_x[rd_bank][0];
                        y_q     <= mem_y[rd_bank][0];
                        drv_q   <= 1'b1;
                    end
                end
                SEND: begin
                    if (snd_idx == 3'd6) begin
                        state <= WAIT;
                        x_q   <= '0;
                        y_q   <= '0;
                        drv_q <= 1'b0;
`ifdef GEOFENCE_DRV_TIMEOUT_EN
                        wait_cnt <= '0;
`endif
                    end else begin
                        snd_idx <= snd_idx + 3'd1;
                        x_q     <= mem_x[rd_bank][snd_idx + 3'd1];
                        y_q     <= mem_y[rd_bank][snd_idx + 3'd1];
                    end
                end
                WAIT: begin
                    if (bus.fence_valid) begin
                        state        <= RESULT;
                        res_valid_q  <= 1'b1;
                        res_inside_q <= bus.fence_inside;
`ifdef GEOFENCE_DRV_TIMEOUT_EN
                        res_timeout_q <= 1'b0;
                    end else if (wait_cnt == 6'd63) begin
                        state         <= RESULT;
                        res_valid_q   <= 1'b1;
                        res_inside_q  <= 1'b0;
                        res_timeout_q <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 6'd1;
`endif
                    end
                end
                RESULT: begin
                    full[rd_bank] <= 1'b0;
                    rd_bank       <= ~rd_bank;
                    set_q         <= set_q + 8'd1;
                    if (res_inside_q) inside_q <= inside_q + 8'd1;
                    if (oth_fill) begin
                        state   <= SEND;
                        snd_idx <= '0;
                        x_q     <= mem_x[~rd_bank][0];
                        y_q     <= mem_y[~rd_bank][0];
                        drv_q   <= 1'b1;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_geofence_driver.sv
// Directed self-checking bench for geofence_driver (honours GEOFENCE_DRV_TIMEOUT_EN).
module tb_geofence_driver;
    logic clk;
    logic reset;
    geofence_driver_if bus ();

    geofence_driver dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;
    int n_fail = 0;
    logic [9:0] vx [32];
    logic [9:0] vy [32];
    int pidx = 0;
    int npts = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One clock; points stream from vx/vy whenever the DUT accepts them.
    task automatic cyc();
        logic acc;
        acc = bus.in_valid && bus.in_ready;
        @(posedge clk);
        #1;
        if (acc) pidx++;
        if (pidx < npts) begin
            bus.in_valid = 1'b1;
            bus.in_x     = vx[pidx];
            bus.in_y     = vy[pidx];
        end else begin
            bus.in_valid = 1'b0;
        end
    endtask

    task automatic start_stream(input int n);
        pidx         = 0;
        npts         = n;
        bus.in_valid = 1'b1;
        bus.in_x     = vx[0];
        bus.in_y     = vy[0];
    endtask

    // Called in SEND cycle 0; leaves time in SEND cycle 6.
    task automatic expect_burst(input int base, input bit pulse_fv);
        for (int k = 0; k < 7; k++) begin
            if (k > 0) begin
                if (pulse_fv && k == 2) bus.fence_valid = 1'b1;
                cyc();
                bus.fence_valid = 1'b0;
            end
            chk("burst_x", bus.X, vx[base + k]);
            chk("burst_y", bus.Y, vy[base + k]);
            chk("burst_drv", bus.drv_active, 1);
            chk("burst_noresult", bus.res_valid, 0);
        end
    endtask

    initial begin
        bus.in_valid     = 1'b0;
        bus.in_x         = '0;
        bus.in_y         = '0;
        bus.fence_valid  = 1'b0;
        bus.fence_inside = 1'b0;
        reset            = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_x", bus.X, 0);
        chk("rst_y", bus.Y, 0);
        chk("rst_drv", bus.drv_active, 0);
        chk("rst_res_valid", bus.res_valid, 0);
        chk("rst_res_inside", bus.res_inside, 0);
        chk("rst_res_timeout", bus.res_timeout, 0);
        chk("rst_set_cnt", bus.set_cnt, 0);
        chk("rst_inside_cnt", bus.inside_cnt, 0);
        reset = 1'b0;
        cyc();
        chk("rst_in_ready", bus.in_ready, 1);

        // Square-ish fence around (100,100)
        vx[0] = 10'd100; vy[0] = 10'd100;
        vx[1] = 10'd50;  vy[1] = 10'd50;
        vx[2] = 10'd150; vy[2] = 10'd50;
        vx[3] = 10'd200; vy[3] = 10'd100;
        vx[4] = 10'd150; vy[4] = 10'd150;
        vx[5] = 10'd50;  vy[5] = 10'd150;
        vx[6] = 10'd0;   vy[6] = 10'd100;
        start_stream(7);
        repeat (7) cyc();
        expect_burst(0, 1'b0);
        cyc();
        chk("wait_x", bus.X, 0);
        chk("wait_y", bus.Y, 0);
        chk("wait_drv", bus.drv_active, 0);
        cyc();
        chk("wait_no_result", bus.res_valid, 0);
        bus.fence_valid = 1'b1; bus.fence_inside = 1'b1;
        cyc();
        bus.fence_valid = 1'b0; bus.fence_inside = 1'b0;
        chk("res1_valid", bus.res_valid, 1);
        chk("res1_inside", bus.res_inside, 1);
        chk("res1_timeout", bus.res_timeout, 0);
        cyc();
        chk("res1_pulse_end", bus.res_valid, 0);
        chk("res1_set_cnt", bus.set_cnt, 1);
        chk("res1_inside_cnt", bus.inside_cnt, 1);
        chk("idle_drv", bus.drv_active, 0);

        // fence_valid in IDLE is ignored
        bus.fence_valid = 1'b1; bus.fence_inside = 1'b1;
        cyc();
        bus.fence_valid = 1'b0; bus.fence_inside = 1'b0;
        chk("idle_fv_no_result", bus.res_valid, 0);
        cyc();
        chk("idle_fv_no_result2", bus.res_valid, 0);
        chk("idle_fv_set_cnt", bus.set_cnt, 1);
        chk("idle_fv_inside_cnt", bus.inside_cnt, 1);

        // 21 points back to back; fence pulse during first burst is ignored
        for (int i = 0; i < 21; i++) begin
            vx[i] = 10'(i * 7 + 3);
            vy[i] = 10'(1000 - i);
        end
        start_stream(21);
        repeat (7) cyc();
        expect_burst(0, 1'b1);
        chk("bb_ready_13pts", bus.in_ready, 1);
        cyc();
        chk("bb_ready_low_14pts", bus.in_ready, 0);
        chk("bb_wait_drv", bus.drv_active, 0);
        chk("bb_send_fv_set_cnt", bus.set_cnt, 1);
        cyc();
        cyc();
        chk("bb_ready_held_low", bus.in_ready, 0);
        chk("bb_no_result", bus.res_valid, 0);
        bus.fence_valid = 1'b1;
        cyc();
        bus.fence_valid = 1'b0;
        chk("bb_res_valid", bus.res_valid, 1);
        chk("bb_res_inside", bus.res_inside, 0);
        chk("bb_ready_in_result", bus.in_ready, 0);
        cyc();
        chk("bb_ready_after_result", bus.in_ready, 1);
        chk("bb_set_cnt2", bus.set_cnt, 2);
        chk("bb_inside_cnt2", bus.inside_cnt, 1);
        expect_burst(7, 1'b0);
        cyc();
        chk("bb_wait2_drv", bus.drv_active, 0);
        chk("bb_ready_low_21pts", bus.in_ready, 0);
        bus.fence_valid = 1'b1; bus.fence_inside = 1'b1;
        cyc();
        bus.fence_valid = 1'b0; bus.fence_inside = 1'b0;
        chk("bb_res2_valid", bus.res_valid, 1);
        chk("bb_res2_inside", bus.res_inside, 1);
        cyc();
        chk("bb_set_cnt3", bus.set_cnt, 3);
        chk("bb_inside_cnt3", bus.inside_cnt, 2);
        chk("bb_ready_after_result2", bus.in_ready, 1);
        expect_burst(14, 1'b0);
        cyc();
        bus.fence_valid = 1'b1; bus.fence_inside = 1'b0;
        cyc();
        bus.fence_valid = 1'b0;
        cyc();
        chk("bb_set_cnt4", bus.set_cnt, 4);
        chk("bb_inside_cnt4", bus.inside_cnt, 2);
        chk("bb_idle_drv", bus.drv_active, 0);

        // Reset on SEND cycle 3 after 10 points loaded
        for (int i = 0; i < 10; i++) begin
            vx[i] = 10'(i * 11 + 5);
            vy[i] = 10'(i * 13 + 2);
        end
        start_stream(10);
        repeat (7) cyc();
        repeat (3) cyc();
        chk("mid_send_x3", bus.X, vx[3]);
        reset = 1'b1;
        bus.fence_valid = 1'b1;
        cyc();
        reset = 1'b0;
        bus.fence_valid = 1'b0;
        chk("mrst_x", bus.X, 0);
        chk("mrst_y", bus.Y, 0);
        chk("mrst_drv", bus.drv_active, 0);
        chk("mrst_set_cnt", bus.set_cnt, 0);
        chk("mrst_inside_cnt", bus.inside_cnt, 0);
        chk("mrst_res_valid", bus.res_valid, 0);
        chk("mrst_in_ready", bus.in_ready, 1);
        cyc();
        chk("mrst_stays_idle", bus.drv_active, 0);
        for (int i = 0; i < 7; i++) begin
            vx[i] = 10'(1023 - i * 37);
            vy[i] = 10'(i * 91 + 1);
        end
        start_stream(7);
        repeat (7) cyc();
        expect_burst(0, 1'b0);
        cyc();
`ifdef GEOFENCE_DRV_TIMEOUT_EN
        repeat (63) cyc();
        chk("to_wait64_no_result", bus.res_valid, 0);
        chk("to_wait64_drv", bus.drv_active, 0);
        cyc();
        chk("to_res_valid", bus.res_valid, 1);
        chk("to_res_timeout", bus.res_timeout, 1);
        chk("to_res_inside", bus.res_inside, 0);
        cyc();
        chk("to_set_cnt", bus.set_cnt, 1);
        chk("to_inside_cnt", bus.inside_cnt, 0);
        chk("to_pulse_end", bus.res_valid, 0);
`else
        repeat (70) cyc();
        chk("nto_still_waiting", bus.res_valid, 0);
        chk("nto_set_cnt0", bus.set_cnt, 0);
        bus.fence_valid = 1'b1; bus.fence_inside = 1'b0;
        cyc();
        bus.fence_valid = 1'b0;
        chk("nto_res_valid", bus.res_valid, 1);
        chk("nto_res_timeout", bus.res_timeout, 0);
        cyc();
        chk("nto_set_cnt", bus.set_cnt, 1);
        chk("nto_inside_cnt", bus.inside_cnt, 0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
